// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush,
// downstream hold and saturating stall/flush performance counters.
module idex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_npc,
    input  logic [DATA_W-1:0] id_a,
    input  logic [DATA_W-1:0] id_b,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [1:0]        id_wb,
    input  logic [2:0]        id_m,
    input  logic [3:0]        id_ex,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_npc,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [1:0]        ex_wb,
    output logic [2:0]        ex_m,
    output logic [3:0]        ex_ex,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] npc_q, npc_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
    logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [1:0]        wb_q, wb_d;
    logic [2:0]        m_q, m_d;
    logic [3:0]        exc_q, exc_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic              hazard;

    // Load in EX whose destination feeds a source of the decode instruction; $0 never counts
    assign hazard = valid_q & m_q[1] & id_valid & (rt_q != '0)
                  & ((rt_q == id_rs) | (rt_q == id_rt));

    // Upstream freeze; a flush discards the decode slot so no stall is needed
    assign id_stall = ~flush & (ex_hold | hazard);

    // Next-state selection: flush > hold > bubble > load
    always_comb begin
        valid_d     = valid_q;
        npc_d       = npc_q;
        a_d         = a_q;
        b_d         = b_q;
        imm_d       = imm_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
        wb_d        = wb_q;
        m_d         = m_q;
        exc_d       = exc_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (flush || (!ex_hold && hazard)) begin
            valid_d = 1'b0;
            npc_d   = '0;
            a_d     = '0;
            b_d     = '0;
            imm_d   = '0;
            rs_d    = '0;
            rt_d    = '0;
            rd_d    = '0;
            wb_d    = '0;
            m_d     = '0;
            exc_d   = '0;
            if (flush) begin
                if (id_valid && (flush_cnt_q != '1)) begin
                    flush_cnt_d = flush_cnt_q + CNT_W'(1);
                end
            end else if (stall_cnt_q != '1) begin
                stall_cnt_d = stall_cnt_q + CNT_W'(1);
            end
        end else if (!ex_hold) begin
            valid_d = id_valid;
            npc_d   = id_npc;
            a_d     = id_a;
            b_d     = id_b;
            imm_d   = id_imm;
            rs_d    = id_rs;
            rt_d    = id_rt;
            rd_d    = id_rd;
            wb_d    = id_valid ? id_wb : 2'b00;
            m_d     = id_valid ? id_m  : 3'b000;
            exc_d   = id_valid ? id_ex : 4'b0000;
        end
    end

    // Pipeline latch and counters with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            npc_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            imm_q       <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            wb_q        <= '0;
            m_q         <= '0;
            exc_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            npc_q       <= npc_d;
            a_q         <= a_d;
            b_q         <= b_d;
            imm_q       <= imm_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            wb_q        <= wb_d;
            m_q         <= m_d;
            exc_q       <= exc_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid  = valid_q;
    assign ex_npc    = npc_q;
    assign ex_a      = a_q;
    assign ex_b      = b_q;
    assign ex_imm    = imm_q;
    assign ex_rs     = rs_q;
    assign ex_rt     = rt_q;
    assign ex_rd     = rd_q;
    assign ex_wb     = wb_q;
    assign ex_m      = m_q;
    assign ex_ex     = exc_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_idex_stage.sv
// Directed bench for idex_stage, built with 4-bit counters to reach saturation.
module tb_idex_stage;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [DATA_W-1:0] id_npc, id_a, id_b, id_imm;
    logic [REG_AW-1:0] id_rs, id_rt, id_rd;
    logic [1:0]        id_wb;
    logic [2:0]        id_m;
    logic [3:0]        id_ex;
    logic              flush, ex_hold;
    logic              id_stall, ex_valid;
    logic [DATA_W-1:0] ex_npc, ex_a, ex_b, ex_imm;
    logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
    logic [1:0]        ex_wb;
    logic [2:0]        ex_m;
    logic [3:0]        ex_ex;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_stall;

    idex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_npc(id_npc),
        .id_a(id_a), .id_b(id_b), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_wb(id_wb), .id_m(id_m), .id_ex(id_ex),
        .flush(flush), .ex_hold(ex_hold), .id_stall(id_stall),
        .ex_valid(ex_valid), .ex_npc(ex_npc), .ex_a(ex_a), .ex_b(ex_b),
        .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_wb(ex_wb), .ex_m(ex_m), .ex_ex(ex_ex),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction; settle combinational outputs afterwards
    task automatic present(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [2:0] m, input logic [31:0] a);
        id_valid = v;
        id_rs    = rs;
        id_rt    = rt;
        id_m     = m;
        id_a     = a;
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; ex_hold = 1'b0;
        id_valid = 1'b0; id_npc = '0; id_a = '0; id_b = '0; id_imm = '0;
        id_rs = '0; id_rt = '0; id_rd = '0; id_wb = '0; id_m = '0; id_ex = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_valid", 64'(ex_valid), 64'd0);
        chk("rst_a", 64'(ex_a), 64'd0);
        chk("rst_wb", 64'(ex_wb), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_flush_cnt", 64'(flush_cnt), 64'd0);
        chk("rst_id_stall", 64'(id_stall), 64'd0);

        // Normal load, one-cycle latency
        id_b = 32'h00100022; id_imm = 32'hFFFFFFF0; id_wb = 2'b10; id_ex = 4'b1100;
        id_npc = 32'h00000104; id_rd = 5'd3;
        present(1'b1, 5'd1, 5'd2, 3'b000, 32'h10654321);
        chk("load_id_stall", 64'(id_stall), 64'd0);
        step();
        chk("load_valid", 64'(ex_valid), 64'd1);
        chk("load_a", 64'(ex_a), 64'h10654321);
        chk("load_b", 64'(ex_b), 64'h00100022);
        chk("load_imm", 64'(ex_imm), 64'hFFFFFFF0);
        chk("load_wb", 64'(ex_wb), 64'h2);
        chk("load_ex", 64'(ex_ex), 64'hC);
        chk("load_npc", 64'(ex_npc), 64'h104);
        chk("load_rd", 64'(ex_rd), 64'd3);
        chk("load_stall_cnt", 64'(stall_cnt), 64'd0);

        // Load-use on rs
        present(1'b1, 5'd1, 5'd8, 3'b010, 32'h11111111);
        chk("lw_no_stall", 64'(id_stall), 64'd0);
        step();
        chk("lw_m", 64'(ex_m), 64'h2);
        chk("lw_rt", 64'(ex_rt), 64'd8);
        present(1'b1, 5'd8, 5'd9, 3'b000, 32'h22222222);
        chk("hz_rs_stall", 64'(id_stall), 64'd1);
        step();
        chk("bubble_valid", 64'(ex_valid), 64'd0);
        chk("bubble_m", 64'(ex_m), 64'd0);
        chk("bubble_wb", 64'(ex_wb), 64'd0);
        chk("bubble_a", 64'(ex_a), 64'd0);
        chk("bubble_stall_cnt", 64'(stall_cnt), 64'd1);
        chk("bubble_id_stall", 64'(id_stall), 64'd0);
        step();
        chk("replay_valid", 64'(ex_valid), 64'd1);
        chk("replay_rs", 64'(ex_rs), 64'd8);
        chk("replay_a", 64'(ex_a), 64'h22222222);
        chk("replay_stall_cnt", 64'(stall_cnt), 64'd1);

        // Load to $0 never stalls
        present(1'b1, 5'd0, 5'd0, 3'b010, 32'h33333333);
        step();
        present(1'b1, 5'd0, 5'd4, 3'b000, 32'h44444444);
        chk("r0_no_stall", 64'(id_stall), 64'd0);
        step();
        chk("r0_valid", 64'(ex_valid), 64'd1);
        chk("r0_stall_cnt", 64'(stall_cnt), 64'd1);

        // Load-use on rt only
        present(1'b1, 5'd7, 5'd3, 3'b010, 32'h55555555);
        step();
        present(1'b1, 5'd6, 5'd3, 3'b000, 32'h66666666);
        chk("hz_rt_stall", 64'(id_stall), 64'd1);
        step();
        chk("hz_rt_valid", 64'(ex_valid), 64'd0);
        chk("hz_rt_stall_cnt", 64'(stall_cnt), 64'd2);

        // Flush beats a concurrent hazard
        present(1'b1, 5'd1, 5'd8, 3'b010, 32'h77777777);
        step();
        chk("lw2_m", 64'(ex_m), 64'h2);
        flush = 1'b1;
        present(1'b1, 5'd8, 5'd9, 3'b000, 32'h88888888);
        chk("flush_id_stall", 64'(id_stall), 64'd0);
        step();
        flush = 1'b0;
        chk("flush_valid", 64'(ex_valid), 64'd0);
        chk("flush_m", 64'(ex_m), 64'd0);
        chk("flush_flush_cnt", 64'(flush_cnt), 64'd1);
        chk("flush_stall_cnt", 64'(stall_cnt), 64'd2);

        // Hold freezes the latch for three cycles
        present(1'b1, 5'd2, 5'd4, 3'b000, 32'hAAAA0001);
        step();
        chk("pre_hold_a", 64'(ex_a), 64'hAAAA0001);
        ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            present(1'b1, 5'd10 + 5'(i), 5'd11, 3'b000, 32'h50000000 + 32'(i));
            chk("hold_id_stall", 64'(id_stall), 64'd1);
            step();
            chk("hold_a", 64'(ex_a), 64'hAAAA0001);
            chk("hold_rs", 64'(ex_rs), 64'd2);
            chk("hold_stall_cnt", 64'(stall_cnt), 64'd2);
            chk("hold_flush_cnt", 64'(flush_cnt), 64'd1);
        end
        ex_hold = 1'b0;
        present(1'b1, 5'd12, 5'd13, 3'b000, 32'h60000000);
        step();
        chk("post_hold_a", 64'(ex_a), 64'h60000000);
        chk("post_hold_rs", 64'(ex_rs), 64'd12);

        // Flush beats hold
        ex_hold = 1'b1; flush = 1'b1;
        present(1'b1, 5'd1, 5'd2, 3'b000, 32'h70000000);
        chk("flush_hold_id_stall", 64'(id_stall), 64'd0);
        step();
        ex_hold = 1'b0; flush = 1'b0;
        chk("flush_hold_valid", 64'(ex_valid), 64'd0);
        chk("flush_hold_flush_cnt", 64'(flush_cnt), 64'd2);

        // Hold beats hazard: latch frozen, no count
        present(1'b1, 5'd1, 5'd5, 3'b010, 32'h90000000);
        step();
        ex_hold = 1'b1;
        present(1'b1, 5'd5, 5'd6, 3'b000, 32'h91000000);
        chk("hold_hz_id_stall", 64'(id_stall), 64'd1);
        step();
        ex_hold = 1'b0;
        chk("hold_hz_valid", 64'(ex_valid), 64'd1);
        chk("hold_hz_a", 64'(ex_a), 64'h90000000);
        chk("hold_hz_stall_cnt", 64'(stall_cnt), 64'd2);
        step();
        chk("hold_hz_bubble_cnt", 64'(stall_cnt), 64'd3);

        // Twenty bubbles saturate the 4-bit stall counter
        exp_stall = 3;
        for (int i = 0; i < 20; i++) begin
            present(1'b1, 5'd1, 5'd5, 3'b010, 32'hB0000000);
            step();
            present(1'b1, 5'd5, 5'd6, 3'b000, 32'hC0000000);
            chk("sat_id_stall", 64'(id_stall), 64'd1);
            step();
            exp_stall = (exp_stall == 15) ? 15 : exp_stall + 1;
            chk("sat_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        end
        chk("sat_final", 64'(stall_cnt), 64'hF);

        // Reset in the middle of a hazard
        present(1'b1, 5'd1, 5'd5, 3'b010, 32'hD0000000);
        step();
        present(1'b1, 5'd5, 5'd6, 3'b000, 32'hE0000000);
        chk("pre_rst_id_stall", 64'(id_stall), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", 64'(ex_valid), 64'd0);
        chk("mid_rst_id_stall", 64'(id_stall), 64'd0);
        chk("mid_rst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("mid_rst_flush_cnt", 64'(flush_cnt), 64'd0);
        chk("mid_rst_a", 64'(ex_a), 64'd0);
        chk("mid_rst_m", 64'(ex_m), 64'd0);
        chk("mid_rst_wb", 64'(ex_wb), 64'd0);
        chk("mid_rst_rt", 64'(ex_rt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
